// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: stall/hold, bubble, interrupt flush, Tnew aging.
// Optional perf counters built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANES  = 2,
    parameter int unsigned TNEW_W = 2,
    parameter logic [DATA_W-1:0] PC_RST = 32'h0000_3000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    int_exc_req_i,
    input  logic                    flush_i,
    input  logic                    stall_i,
    input  logic                    valid_i,
    input  logic [DATA_W-1:0]       instr_i,
    input  logic [DATA_W-1:0]       pc_i,
    input  logic                    bd_i,
    input  logic [LANES*DATA_W-1:0] lanes_i,
    input  logic [4:0]              wr_addr_i,
    input  logic                    reg_write_i,
    input  logic [TNEW_W-1:0]       tnew_i,
    output logic                    valid_o,
    output logic [DATA_W-1:0]       instr_o,
    output logic [DATA_W-1:0]       pc_o,
    output logic                    bd_o,
    output logic [LANES*DATA_W-1:0] lanes_o,
    output logic [4:0]              wr_addr_o,
    output logic                    reg_write_o,
    output logic [TNEW_W-1:0]       tnew_o,
    output logic [31:0]             perf_stall_o,
    output logic [31:0]             perf_bubble_o
);

    typedef enum logic [4:0] {
        OP_RST   = 5'b00001,
        OP_INT   = 5'b00010,
        OP_FLUSH = 5'b00100,
        OP_STALL = 5'b01000,
        OP_LOAD  = 5'b10000
    } op_e;

    op_e op;

    logic                    valid_q, valid_d;
    logic [DATA_W-1:0]       instr_q, instr_d;
    logic [DATA_W-1:0]       pc_q, pc_d;
    logic                    bd_q, bd_d;
    logic [LANES*DATA_W-1:0] lanes_q, lanes_d;
    logic [4:0]              wr_addr_q, wr_addr_d;
    logic                    reg_write_q, reg_write_d;
    logic [TNEW_W-1:0]       tnew_q, tnew_d;

    function automatic logic [TNEW_W-1:0] dec_sat(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

    // Resolve the control priority once so the datapath sees a one-hot op.
    always_comb begin
        if (reset)              op = OP_RST;
        else if (int_exc_req_i) op = OP_INT;
        else if (flush_i)       op = OP_FLUSH;
        else if (stall_i)       op = OP_STALL;
        else                    op = OP_LOAD;
    end

    always_comb begin
        valid_d     = valid_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        bd_d        = bd_q;
        lanes_d     = lanes_q;
        wr_addr_d   = wr_addr_q;
        reg_write_d = reg_write_q;
        tnew_d      = tnew_q;
        unique case (op)
            OP_RST, OP_INT: begin
                valid_d     = 1'b0;
                instr_d     = '0;
                pc_d        = PC_RST;
                bd_d        = 1'b0;
                lanes_d     = '0;
                wr_addr_d   = '0;
                reg_write_d = 1'b0;
                tnew_d      = '0;
            end
            OP_FLUSH: begin
                // Keep pc/bd so a later EPC still names the killed slot.
                valid_d     = 1'b0;
                instr_d     = '0;
                pc_d        = pc_i;
                bd_d        = bd_i;
                lanes_d     = '0;
                wr_addr_d   = '0;
                reg_write_d = 1'b0;
                tnew_d      = '0;
            end
            OP_STALL: begin
                tnew_d = dec_sat(tnew_q);
            end
            OP_LOAD: begin
                valid_d     = valid_i;
                instr_d     = instr_i;
                pc_d        = pc_i;
                bd_d        = bd_i;
                lanes_d     = lanes_i;
                wr_addr_d   = valid_i ? wr_addr_i : 5'd0;
                reg_write_d = reg_write_i & valid_i;
                tnew_d      = dec_sat(tnew_i);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        valid_q     <= valid_d;
        instr_q     <= instr_d;
        pc_q        <= pc_d;
        bd_q        <= bd_d;
        lanes_q     <= lanes_d;
        wr_addr_q   <= wr_addr_d;
        reg_write_q <= reg_write_d;
        tnew_q      <= tnew_d;
    end

    assign valid_o     = valid_q;
    assign instr_o     = instr_q;
    assign pc_o        = pc_q;
    assign bd_o        = bd_q;
    assign lanes_o     = lanes_q;
    assign wr_addr_o   = wr_addr_q;
    assign reg_write_o = reg_write_q;
    assign tnew_o      = tnew_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        unique case (op)
            OP_RST: begin
                stall_cnt_d  = '0;
                bubble_cnt_d = '0;
            end
            OP_FLUSH: begin
                if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + 32'd1;
            end
            OP_STALL: begin
                if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        stall_cnt_q  <= stall_cnt_d;
        bubble_cnt_q <= bubble_cnt_d;
    end

    assign perf_stall_o  = stall_cnt_q;
    assign perf_bubble_o = bubble_cnt_q;
`else
    assign perf_stall_o  = 32'd0;
    assign perf_bubble_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed table-driven bench for pipe_stage_reg, plus a LANES=3/TNEW_W=3
// instance for Tnew saturation and wide-lane pass-through.
`timescale 1ns/1ps
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset, int_exc_req_i, flush_i, stall_i, valid_i, bd_i, reg_write_i;
    logic [31:0] instr_i, pc_i;
    logic [63:0] lanes_i;
    logic [4:0]  wr_addr_i;
    logic [1:0]  tnew_i;

    logic        valid_o, bd_o, reg_write_o;
    logic [31:0] instr_o, pc_o, perf_stall_o, perf_bubble_o;
    logic [63:0] lanes_o;
    logic [4:0]  wr_addr_o;
    logic [1:0]  tnew_o;

    logic [95:0] lanes3_i, lanes3_o;
    logic [2:0]  tnew3_i, tnew3_o;
    logic        s_valid_o, s_bd_o, s_rw_o;
    logic [31:0] s_instr_o, s_pc_o, s_ps_o, s_pb_o;
    logic [4:0]  s_wa_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .LANES(2), .TNEW_W(2)) dut (
        .clk(clk), .reset(reset), .int_exc_req_i(int_exc_req_i),
        .flush_i(flush_i), .stall_i(stall_i), .valid_i(valid_i),
        .instr_i(instr_i), .pc_i(pc_i), .bd_i(bd_i), .lanes_i(lanes_i),
        .wr_addr_i(wr_addr_i), .reg_write_i(reg_write_i), .tnew_i(tnew_i),
        .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o), .bd_o(bd_o),
        .lanes_o(lanes_o), .wr_addr_o(wr_addr_o), .reg_write_o(reg_write_o),
        .tnew_o(tnew_o), .perf_stall_o(perf_stall_o),
        .perf_bubble_o(perf_bubble_o)
    );

    pipe_stage_reg #(.DATA_W(32), .LANES(3), .TNEW_W(3)) u_sat (
        .clk(clk), .reset(reset), .int_exc_req_i(int_exc_req_i),
        .flush_i(flush_i), .stall_i(stall_i), .valid_i(valid_i),
        .instr_i(instr_i), .pc_i(pc_i), .bd_i(bd_i), .lanes_i(lanes3_i),
        .wr_addr_i(wr_addr_i), .reg_write_i(reg_write_i), .tnew_i(tnew3_i),
        .valid_o(s_valid_o), .instr_o(s_instr_o), .pc_o(s_pc_o), .bd_o(s_bd_o),
        .lanes_o(lanes3_o), .wr_addr_o(s_wa_o), .reg_write_o(s_rw_o),
        .tnew_o(tnew3_o), .perf_stall_o(s_ps_o), .perf_bubble_o(s_pb_o)
    );

    typedef struct {
        logic        rst, irq, fl, st, v;
        logic [31:0] instr, pc;
        logic        bd;
        logic [63:0] lanes;
        logic [4:0]  wa;
        logic        rw;
        logic [1:0]  tn;
        logic        ev;
        logic [31:0] ei, ep;
        logic        eb;
        logic [63:0] el;
        logic [4:0]  ew;
        logic        er;
        logic [1:0]  et;
        logic [31:0] es, ebub;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int idx,
                       input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    function automatic logic [31:0] perf_exp(input logic [31:0] v);
`ifdef PIPE_STAGE_PERF_EN
        return v;
`else
        return (v == 32'hFFFF_FFFF) ? 32'd0 : 32'd0;
`endif
    endfunction

    initial begin
        //        rst irq fl st v  instr          pc            bd lanes                                 wa  rw tn
        //        ev  ei             ep            eb el                                    ew  er et  stall bubble
        vecs[0]  = '{1,0,0,0,1, 32'h1234_5678, 32'h0000_5000, 1, {32'h1,32'h2},             5'd9, 1,2'd3,
                     0, 32'h0,          32'h0000_3000, 0, 64'h0,                          5'd0, 0,2'd0, 0,0};
        vecs[1]  = '{0,0,0,0,1, 32'h0109_5021, 32'h0000_3004, 0, {32'hDEAD_BEEF,32'h1},     5'd10,1,2'd2,
                     1, 32'h0109_5021, 32'h0000_3004, 0, {32'hDEAD_BEEF,32'h1},          5'd10,1,2'd1, 0,0};
        vecs[2]  = '{0,0,0,0,0, 32'h8C01_0004, 32'h0000_3008, 1, {32'h5,32'h6},             5'd7, 1,2'd1,
                     0, 32'h8C01_0004, 32'h0000_3008, 1, {32'h5,32'h6},                  5'd0, 0,2'd0, 0,0};
        vecs[3]  = '{0,0,0,0,1, 32'h0022_1820, 32'h0000_300C, 0, {32'hAAAA_5555,32'h1234_5678},5'd3,1,2'd3,
                     1, 32'h0022_1820, 32'h0000_300C, 0, {32'hAAAA_5555,32'h1234_5678},  5'd3, 1,2'd2, 0,0};
        vecs[4]  = '{0,0,0,1,1, 32'hFFFF_FFFF, 32'h0000_4000, 1, {32'h7,32'h8},             5'd1, 0,2'd0,
                     1, 32'h0022_1820, 32'h0000_300C, 0, {32'hAAAA_5555,32'h1234_5678},  5'd3, 1,2'd1, 1,0};
        vecs[5]  = '{0,0,0,1,0, 32'hEEEE_EEEE, 32'h0000_4004, 1, {32'h9,32'hA},             5'd2, 1,2'd3,
                     1, 32'h0022_1820, 32'h0000_300C, 0, {32'hAAAA_5555,32'h1234_5678},  5'd3, 1,2'd0, 2,0};
        vecs[6]  = '{0,0,0,1,1, 32'hDDDD_DDDD, 32'h0000_4008, 0, {32'hB,32'hC},             5'd4, 1,2'd2,
                     1, 32'h0022_1820, 32'h0000_300C, 0, {32'hAAAA_5555,32'h1234_5678},  5'd3, 1,2'd0, 3,0};
        vecs[7]  = '{0,0,0,1,1, 32'hCCCC_CCCC, 32'h0000_400C, 1, {32'hD,32'hE},             5'd6, 0,2'd1,
                     1, 32'h0022_1820, 32'h0000_300C, 0, {32'hAAAA_5555,32'h1234_5678},  5'd3, 1,2'd0, 4,0};
        vecs[8]  = '{0,0,1,1,1, 32'h1111_1111, 32'h0000_3010, 1, {32'h9,32'h9},             5'd5, 1,2'd3,
                     0, 32'h0,          32'h0000_3010, 1, 64'h0,                          5'd0, 0,2'd0, 4,1};
        vecs[9]  = '{0,1,1,0,1, 32'h2222_2222, 32'h0000_3020, 1, {32'h3,32'h4},             5'd8, 1,2'd2,
                     0, 32'h0,          32'h0000_3000, 0, 64'h0,                          5'd0, 0,2'd0, 4,1};
        vecs[10] = '{0,0,0,0,1, 32'hABCD_0001, 32'h0000_3024, 0, {32'h2,32'h3},             5'd31,1,2'd0,
                     1, 32'hABCD_0001, 32'h0000_3024, 0, {32'h2,32'h3},                  5'd31,1,2'd0, 4,1};
        vecs[11] = '{1,0,0,1,1, 32'h3333_3333, 32'h0000_3028, 1, {32'h5,32'h5},             5'd12,1,2'd3,
                     0, 32'h0,          32'h0000_3000, 0, 64'h0,                          5'd0, 0,2'd0, 0,0};
        vecs[12] = '{0,0,1,0,1, 32'h4444_4444, 32'h0000_3030, 0, {32'h6,32'h6},             5'd13,1,2'd1,
                     0, 32'h0,          32'h0000_3030, 0, 64'h0,                          5'd0, 0,2'd0, 0,1};

        reset = 0; int_exc_req_i = 0; flush_i = 0; stall_i = 0; valid_i = 0;
        instr_i = 0; pc_i = 0; bd_i = 0; lanes_i = 0; wr_addr_i = 0;
        reg_write_i = 0; tnew_i = 0; lanes3_i = 0; tnew3_i = 0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            reset = vecs[i].rst; int_exc_req_i = vecs[i].irq;
            flush_i = vecs[i].fl; stall_i = vecs[i].st; valid_i = vecs[i].v;
            instr_i = vecs[i].instr; pc_i = vecs[i].pc; bd_i = vecs[i].bd;
            lanes_i = vecs[i].lanes; wr_addr_i = vecs[i].wa;
            reg_write_i = vecs[i].rw; tnew_i = vecs[i].tn;
            @(posedge clk); #1;
            chk("valid", i, 96'(valid_o), 96'(vecs[i].ev));
            chk("instr", i, 96'(instr_o), 96'(vecs[i].ei));
            chk("pc", i, 96'(pc_o), 96'(vecs[i].ep));
            chk("bd", i, 96'(bd_o), 96'(vecs[i].eb));
            chk("lanes", i, 96'(lanes_o), 96'(vecs[i].el));
            chk("wr_addr", i, 96'(wr_addr_o), 96'(vecs[i].ew));
            chk("reg_write", i, 96'(reg_write_o), 96'(vecs[i].er));
            chk("tnew", i, 96'(tnew_o), 96'(vecs[i].et));
            chk("perf_stall", i, 96'(perf_stall_o), 96'(perf_exp(vecs[i].es)));
            chk("perf_bubble", i, 96'(perf_bubble_o), 96'(perf_exp(vecs[i].ebub)));
            @(negedge clk);
        end

        // Interrupt held for two edges keeps the stage cleared.
        int_exc_req_i = 1; flush_i = 0; stall_i = 0; valid_i = 1;
        instr_i = 32'h5555_0000; pc_i = 32'h0000_3040; reg_write_i = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("irq2_pc", 100, 96'(pc_o), 96'(32'h0000_3000));
        chk("irq2_valid", 100, 96'(valid_o), 96'(1'b0));
        chk("irq2_bubble", 100, 96'(perf_bubble_o), 96'(perf_exp(32'd1)));
        @(negedge clk);

        // Wide instance: Tnew saturation and lane 2 pass-through.
        int_exc_req_i = 0; valid_i = 1; reg_write_i = 1;
        lanes3_i = {32'hCAFE_F00D, 32'h2, 32'h1}; tnew3_i = 3'd0;
        @(posedge clk); #1;
        chk("sat_tnew0", 200, 96'(tnew3_o), 96'(3'd0));
        chk("sat_lane2", 200, 96'(lanes3_o[95:64]), 96'(32'hCAFE_F00D));
        chk("sat_lanes", 200, lanes3_o, {32'hCAFE_F00D, 32'h2, 32'h1});
        @(negedge clk);
        tnew3_i = 3'd7;
        @(posedge clk); #1;
        chk("sat_tnew7", 201, 96'(tnew3_o), 96'(3'd6));
        @(negedge clk);
        stall_i = 1; tnew3_i = 3'd0; lanes3_i = '0;
        @(posedge clk); #1;
        chk("sat_hold1", 202, 96'(tnew3_o), 96'(3'd5));
        @(posedge clk); #1;
        chk("sat_hold2", 203, 96'(tnew3_o), 96'(3'd4));
        chk("sat_hold_lane", 203, lanes3_o, {32'hCAFE_F00D, 32'h2, 32'h1});
        @(negedge clk);

        // Release the stall: next edge overwrites the held instruction.
        stall_i = 0; valid_i = 1; instr_i = 32'h6666_0006; pc_i = 32'h0000_3050;
        lanes3_i = {32'h0, 32'h0, 32'h7}; tnew3_i = 3'd1;
        @(posedge clk); #1;
        chk("release_instr", 204, 96'(s_instr_o), 96'(32'h6666_0006));
        chk("release_tnew", 204, 96'(tnew3_o), 96'(3'd0));
        chk("release_lanes", 204, lanes3_o, {32'h0, 32'h0, 32'h7});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // reg_write must never be visible on an invalid slot.
    always @(negedge clk) begin
        if (reg_write_o && !valid_o) begin
            errors++;
            $display("FAIL rw_without_valid: got reg_write=1 valid=0 want reg_write=0");
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core. It replaces the hand-written per-stage registers (D/E, E/M, M/W) with one block. Beyond the plain register it adds stall/hold, bubble insertion, interrupt/exception flush, a saturating hazard-timer (Tnew) countdown and a configurable number of payload lanes. One instance sits between each pair of adjacent stages; the hazard unit drives its stall and flush inputs.

## Interface
- DATA_W, 32: width of instruction, PC and each payload lane.
- LANES, 2: number of DATA_W payload lanes (e.g. rs/rt values, ALU result, GRF write data); min 1.
- TNEW_W, 2: width of the Tnew hazard timer.
- PC_RST, 32'h0000_3000: PC value loaded on reset and interrupt flush.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- int_exc_req_i  in  1  interrupt/exception request; clears stage.
- flush_i  in  1  insert bubble (kill incoming instruction).
- stall_i  in  1  hold current contents.
- valid_i  in  1  incoming instruction is real.
- instr_i  in  DATA_W  instruction word.
- pc_i  in  DATA_W  instruction PC.
- bd_i  in  1  instruction is in a branch delay slot.
- lanes_i  in  LANES*DATA_W  payload; lane k at bits [k*DATA_W +: DATA_W].
- wr_addr_i  in  5  GRF write address.
- reg_write_i  in  1  GRF write enable.
- tnew_i  in  TNEW_W  cycles until the result is available, as seen in the previous stage.
- valid_o, instr_o, pc_o, bd_o, lanes_o, wr_addr_o, reg_write_o, tnew_o  out  (matching widths)  registered copies.
- perf_stall_o  out  32  stall-cycle counter.
- perf_bubble_o  out  32  bubble counter.

## Operation
- Priority per edge: reset > int_exc_req_i > flush_i > stall_i > load.
- **reset:**
  - All outputs become 0.
  - Exception: pc_o = PC_RST.
  - Perf counters become 0.
- **int_exc_req_i:**
  - Same as reset for the datapath fields, including pc_o = PC_RST.
  - Perf counters are not cleared.
- **flush_i (bubble):**
  - valid_o, instr_o, lanes_o, wr_addr_o, reg_write_o and tnew_o become 0.
  - pc_o ← pc_i and bd_o ← bd_i, so that the EPC of a later exception still points at the correct instruction.
  - perf_bubble_o increments.
- **stall_i (hold):**
  - All fields hold their value, except tnew_o ← (tnew_o==0) ? 0 : tnew_o−1.
  - This lets multi-cycle results age while held.
  - perf_stall_o increments.
- **load:**
  - Every field ← its input.
  - tnew_o ← (tnew_i==0) ? 0 : tnew_i−1, saturating at 0; it never wraps.
  - reg_write_o ← reg_write_i & valid_i.
  - wr_addr_o ← valid_i ? wr_addr_i : 0.
- reg_write_o is never 1 while valid_o is 0.
- Perf counters saturate at 32'hFFFF_FFFF.
- stall_i together with flush_i: flush wins and only perf_bubble_o increments.

## Timing
- Latency: 1 cycle from input to output. Outputs come directly from flops; there is no combinational input-to-output path.
- Control inputs are sampled only on the rising edge of clk.
- Asserting reset or int_exc_req_i for one cycle is sufficient; further asserted cycles keep the cleared state.
- Reset mid-stall: reset wins; the held contents are lost.
- A held Tnew of 3 with TNEW_W=2 reads 2, 1, 0, 0, … on successive stalled edges.
- Stall deasserted after N cycles: the next edge loads new inputs; the held instruction is overwritten.

## Configuration
- PIPE_STAGE_PERF_EN
  - Defined: both perf counters are implemented as described.
  - Undefined: no counter flops are built, and perf_stall_o and perf_bubble_o are constant 0.
- The datapath behaviour is identical in both cases.

## Test plan
- **Reset:** reset=1 for one edge → pc_o=32'h0000_3000, every other output 0, perf counters 0.
- **Load:**
  - Stimulus: valid_i=1, instr_i=32'h0109_5021, pc_i=32'h3004, lanes_i={32'hDEAD_BEEF, 32'h1}, wr_addr_i=10, reg_write_i=1, tnew_i=2.
  - Required after one edge: the same values on the outputs, with tnew_o=1.
  - With valid_i=0 instead: reg_write_o=0 and wr_addr_o=0.
- **Stall:** after a load with tnew_i=3 (tnew_o=2), hold stall_i=1 for 4 edges while the inputs change → tnew_o reads 1, 0, 0, 0; other fields unchanged; perf_stall_o=4 (macro defined) or 0 (undefined).
- **Flush with stall:** flush_i=1 and stall_i=1 with pc_i=32'h3010, bd_i=1 → valid_o=0, instr_o=0, reg_write_o=0, pc_o=32'h3010, bd_o=1; only perf_bubble_o increments.
- **Interrupt over flush:** int_exc_req_i=1 and flush_i=1 with pc_i=32'h3020 → pc_o=32'h0000_3000, all else 0; perf counters keep their values.
- **Saturation:** with LANES=3 and TNEW_W=3, load tnew_i=0 → tnew_o=0, no wrap; lane 2 (bits [95:64]) passes through intact.
